// File: rtl/l2_pool_pkg.sv
// Shared types and default dimensions for the layer-2 2x2 pooling stage.
package l2_pool_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        PUSH  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int DW_DEF   = 18;
    localparam int NCH_DEF  = 4;
    localparam int WIN_DEF  = 4;
    localparam int NWIN_DEF = 25;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_maxpool_if.sv
// Sample-in / pooled-out valid-ready bus of the layer-2 pooling stage.
interface l2_maxpool_if #(
    parameter int DW = 18
);
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_rdy;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;

    modport slave (
        input  din, din_vld, dout_rdy,
        output din_rdy, dout, dout_vld
    );

    modport master (
        output din, din_vld, dout_rdy,
        input  din_rdy, dout, dout_vld
    );
endinterface

// File: rtl/l2_pool_fifo.sv
// Synchronous FIFO with count-based full/empty and a registered head output.
// clr is a synchronous flush that empties the FIFO and zeroes dout.
module l2_pool_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CNTW-1:0] r_cnt;
    logic [DW-1:0]   r_dout;

    logic            w_pop;
    logic            w_push;
    logic [AW-1:0]   w_rd_nxt;
    logic [CNTW-1:0] w_cnt_nxt;

    assign full  = (r_cnt == CNTW'(DEPTH));
    assign empty = (r_cnt == '0);
    assign dout  = r_dout;

    assign w_pop     = pop && !empty;
    assign w_push    = push && (!full || w_pop);
    assign w_rd_nxt  = r_rd + AW'(w_pop);
    assign w_cnt_nxt = r_cnt + CNTW'(w_push) - CNTW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    // dout is prefetched: it always holds the entry that will be the head next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else if (clr) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            r_rd  <= w_rd_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt != '0) begin
                r_dout <= (w_push && (r_wr == w_rd_nxt)) ? din : r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/l2_maxpool.sv
// 2x2 pooling of the layer-2 post-ReLU stream: WIN positions x NCH channels per window.
// Define L2_POOL_AVG_EN to reduce each window by signed average (WIN must be 4) instead of max.
module l2_maxpool
    import l2_pool_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int NCH        = NCH_DEF,
    parameter int WIN        = WIN_DEF,
    parameter int NWIN       = NWIN_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_done,
    l2_maxpool_if.slave pool,
    output logic        done
);
    // state | meaning
    // ACCUM | taking samples, reducing into per-channel registers
    // PUSH  | writing the NCH reduced values into the FIFO, stalls while full
    // DRAIN | frame complete, waiting for the FIFO to empty
    // HALT  | frame delivered, idle until tx_done

    localparam int CW = clog2_min1(NCH);
    localparam int EW = clog2_min1(WIN);
    localparam int NW = $clog2(NWIN + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_c;
    logic [CW-1:0] r_p;
    logic [EW-1:0] r_e;
    logic [NW-1:0] r_win;
    logic          r_done;

    logic          w_accept;
    logic          w_last_in;
    logic          w_push;
    logic          w_last_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_set_done;
    logic [DW-1:0] w_push_data;

    assign pool.din_rdy  = (r_state == ACCUM);
    assign pool.dout_vld = !w_empty;
    assign done          = r_done;

    assign w_accept    = pool.din_vld && (r_state == ACCUM) && !tx_done;
    assign w_last_in   = w_accept && (r_e == EW'(WIN - 1)) && (r_c == CW'(NCH - 1));
    assign w_push      = (r_state == PUSH) && !w_full && !tx_done;
    assign w_last_push = w_push && (r_p == CW'(NCH - 1));
    assign w_pop       = pool.dout_vld && pool.dout_rdy;
    assign w_set_done  = (r_state == DRAIN) && w_empty && !tx_done;

    always_comb begin
        w_next = r_state;
        if (tx_done) begin
            w_next = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_last_in) w_next = PUSH;
                PUSH:    if (w_last_push) w_next = (r_win == NW'(NWIN - 1)) ? DRAIN : ACCUM;
                DRAIN:   if (w_empty) w_next = HALT;
                HALT:    w_next = HALT;
                default: w_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_c     <= '0;
            r_e     <= '0;
            r_p     <= '0;
            r_win   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_set_done;
            if (tx_done) begin
                r_c   <= '0;
                r_e   <= '0;
                r_p   <= '0;
                r_win <= '0;
            end else begin
                if (w_accept) begin
                    r_c <= (r_c == CW'(NCH - 1)) ? '0 : r_c + CW'(1);
                    if (r_c == CW'(NCH - 1)) begin
                        r_e <= (r_e == EW'(WIN - 1)) ? '0 : r_e + EW'(1);
                    end
                end
                if (w_push) begin
                    r_p <= w_last_push ? '0 : r_p + CW'(1);
                end
                if (w_last_push) begin
                    r_win <= r_win + NW'(1);
                end
            end
        end
    end

`ifdef L2_POOL_AVG_EN
    // Two guard bits hold the sum of four samples; >>>2 floors toward -inf.
    logic signed [DW+1:0] r_acc [NCH];
    logic signed [DW+1:0] w_din_ext;

    assign w_din_ext   = {{2{pool.din[DW-1]}}, pool.din};
    assign w_push_data = DW'(r_acc[r_p] >>> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
        end else if (w_accept) begin
            r_acc[r_c] <= (r_e == '0) ? w_din_ext : r_acc[r_c] + w_din_ext;
        end
    end
`else
    logic [DW-1:0] r_max [NCH];

    assign w_push_data = r_max[r_p];

    // Position 0 loads unconditionally so a window of all-negative samples is not clamped to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) r_max[i] <= '0;
        end else if (w_accept) begin
            if ((r_e == '0) || ($signed(pool.din) > $signed(r_max[r_c]))) begin
                r_max[r_c] <= pool.din;
            end
        end
    end
`endif

    l2_pool_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (tx_done),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_data),
        .full  (w_full),
        .empty (w_empty),
        .dout  (pool.dout)
    );

endmodule
